count_direction_decoder: RTL and testbench

COUNT_DIRECTION_DECODER -- requirements
Module: count_direction_decoder

---
 rtl/count_direction_decoder_pkg.sv | 25 ++
 rtl/count_direction_decoder_if.sv | 29 ++
 rtl/count_direction_decoder_step_classifier.sv | 32 +++
 rtl/count_direction_decoder.sv | 135 +++++++++++++
 tb/tb_count_direction_decoder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_direction_decoder_pkg.sv
// Shared encodings for the count direction decoder: FSM states and step classes.
// Also holds the saturating error-counter helper.
package count_direction_decoder_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCK_UP  = 2'd2,
    ST_LOCK_DN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_JUMP = 2'd3
  } step_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == ERR_MAX) ? ERR_MAX : value + 8'd1;
  endfunction

endpackage

// File: rtl/count_direction_decoder_if.sv
// Sample bus into the decoder plus its registered status outputs.
// There is no backpressure: sample_en high on a clk edge means count_in is taken on that edge.
interface count_direction_decoder_if #(
  parameter int WIDTH = 8
);
  import count_direction_decoder_pkg::*;

  logic             sample_en;
  logic [WIDTH-1:0] count_in;
  logic             dir;
  logic             locked;
  logic             hold;
  logic             wrap;
  logic             jump;
  logic             dir_change;
  logic [7:0]       err_cnt;
  state_t           state;

  modport master (
    output sample_en, count_in,
    input  dir, locked, hold, wrap, jump, dir_change, err_cnt, state
  );

  modport slave (
    input  sample_en, count_in,
    output dir, locked, hold, wrap, jump, dir_change, err_cnt, state
  );

endinterface

// File: rtl/count_direction_decoder_step_classifier.sv
// Classifies one sample against the previous one by modular difference.
// wrap marks a legal +1/-1 step that crosses the max/0 boundary.
module step_classifier
  import count_direction_decoder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step,
  output logic             wrap
);

  logic [WIDTH-1:0] delta;

  assign delta = count_in - prev;

  always_comb begin
    step = STEP_JUMP;
    wrap = 1'b0;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      step = STEP_UP;
      wrap = &prev;
    end else if (&delta) begin
      step = STEP_DOWN;
      wrap = (prev == '0);
    end
  end

endmodule

// File: rtl/count_direction_decoder.sv
// Recovers count direction from a sampled counter value, locking after LOCK_N
// consecutive same-direction steps and counting illegal jumps.
module count_direction_decoder
  import count_direction_decoder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOCK_N = 3
) (
  input  logic                      clk,
  input  logic                      clr,
  count_direction_decoder_if.slave  bus
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             run_dir_q, run_dir_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             hold_q, hold_d;
  logic             wrap_q, wrap_d;
  logic             jump_q, jump_d;
  logic             dir_change_q, dir_change_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  step_t step;
  logic  step_wrap;
  logic  step_dir;

  step_classifier #(.WIDTH(WIDTH)) u_step_classifier (
    .prev     (prev_q),
    .count_in (bus.count_in),
    .step     (step),
    .wrap     (step_wrap)
  );

  assign step_dir = (step == STEP_UP);

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    run_dir_d    = run_dir_q;
    prev_d       = prev_q;
    dir_d        = dir_q;
    locked_d     = locked_q;
    hold_d       = hold_q;
    err_cnt_d    = err_cnt_q;
    wrap_d       = 1'b0;
    jump_d       = 1'b0;
    dir_change_d = 1'b0;

    if (bus.sample_en) begin
      prev_d = bus.count_in;
      if (state_q == ST_INIT) begin
        state_d = ST_UNLOCKED;
      end else begin
        case (step)
          STEP_HOLD: hold_d = 1'b1;
          STEP_JUMP: begin
            hold_d    = 1'b0;
            jump_d    = 1'b1;
            locked_d  = 1'b0;
            state_d   = ST_UNLOCKED;
            run_d     = 4'd0;
            err_cnt_d = sat_inc8(err_cnt_q);
          end
          default: begin
            hold_d = 1'b0;
            dir_d  = step_dir;
            wrap_d = step_wrap;
            if (state_q == ST_UNLOCKED) begin
              // run == 0 means no direction established yet (after reset or a jump)
              if (run_q != 4'd0 && run_dir_q == step_dir) begin
                run_d = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + 4'd1;
              end else begin
                run_d     = 4'd1;
                run_dir_d = step_dir;
              end
              if (run_d >= LOCK_RUN) begin
                state_d  = step_dir ? ST_LOCK_UP : ST_LOCK_DN;
                locked_d = 1'b1;
              end
            end else if ((state_q == ST_LOCK_UP) != step_dir) begin
              dir_change_d = 1'b1;
              locked_d     = 1'b0;
              state_d      = ST_UNLOCKED;
              run_d        = 4'd1;
              run_dir_d    = step_dir;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_INIT;
      run_q        <= 4'd0;
      run_dir_q    <= 1'b0;
      prev_q       <= '0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      hold_q       <= 1'b0;
      wrap_q       <= 1'b0;
      jump_q       <= 1'b0;
      dir_change_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      run_dir_q    <= run_dir_d;
      prev_q       <= prev_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      hold_q       <= hold_d;
      wrap_q       <= wrap_d;
      jump_q       <= jump_d;
      dir_change_q <= dir_change_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.dir        = dir_q;
  assign bus.locked     = locked_q;
  assign bus.hold       = hold_q;
  assign bus.wrap       = wrap_q;
  assign bus.jump       = jump_q;
  assign bus.dir_change = dir_change_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// Bench for count_direction_decoder: two instances (LOCK_N=3 and LOCK_N=1) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_count_direction_decoder;
  import count_direction_decoder_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  // clock/reset block
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic sample_en = 1'b0;
  logic [W-1:0] count_in = '0;
  always #5 clk = ~clk;

  count_direction_decoder_if #(.WIDTH(W)) bus0 ();
  count_direction_decoder_if #(.WIDTH(W)) bus1 ();
  assign bus0.sample_en = sample_en;
  assign bus0.count_in  = count_in;
  assign bus1.sample_en = sample_en;
  assign bus1.count_in  = count_in;

  count_direction_decoder #(.WIDTH(W), .LOCK_N(3)) u_dut0 (.clk(clk), .clr(clr), .bus(bus0));
  count_direction_decoder #(.WIDTH(W), .LOCK_N(1)) u_dut1 (.clk(clk), .clr(clr), .bus(bus1));

  logic [5:0] o_flags[2];
  logic [7:0] o_err[2];
  logic [1:0] o_state[2];
  assign o_flags[0] = {bus0.dir, bus0.locked, bus0.hold, bus0.wrap, bus0.jump, bus0.dir_change};
  assign o_flags[1] = {bus1.dir, bus1.locked, bus1.hold, bus1.wrap, bus1.jump, bus1.dir_change};
  assign o_err[0]   = bus0.err_cnt;
  assign o_err[1]   = bus1.err_cnt;
  assign o_state[0] = bus0.state;
  assign o_state[1] = bus1.state;

  // behavioural model: what the outputs must be after the next edge
  int  lock_n[2] = '{3, 1};
  bit  m_have;
  int  m_prev;
  int  m_run[2];
  bit  m_run_dir[2], m_locked[2], m_lock_dir[2];
  bit  m_dir[2], m_hold[2], m_wrap[2], m_jump[2], m_dc[2];
  int  m_err[2];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_on  = 1'b0;

  // scoreboard: every pin of a sequence is queued, then drained at the check point
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_state(input int k);
    if (!m_have) return int'(ST_INIT);
    if (!m_locked[k]) return int'(ST_UNLOCKED);
    return m_lock_dir[k] ? int'(ST_LOCK_UP) : int'(ST_LOCK_DN);
  endfunction

  task automatic model_apply(input bit c, input bit en, input int v);
    int delta;
    bit d;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      m_jump[k] = 1'b0;
      m_dc[k]   = 1'b0;
    end
    if (c) begin
      m_have = 1'b0;
      m_prev = 0;
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0; m_run_dir[k] = 0; m_locked[k] = 0; m_lock_dir[k] = 0;
        m_dir[k] = 0; m_hold[k] = 0; m_err[k] = 0;
      end
      return;
    end
    if (!en) return;
    if (!m_have) begin
      m_have = 1'b1;
      m_prev = v;
      return;
    end
    delta = (v - m_prev + (MASK + 1)) % (MASK + 1);
    m_prev = v;
    for (int k = 0; k < 2; k++) begin
      if (delta == 0) begin
        m_hold[k] = 1'b1;
      end else if (delta == 1 || delta == MASK) begin
        d = (delta == 1);
        m_hold[k] = 1'b0;
        m_dir[k]  = d;
        m_wrap[k] = d ? (v == 0) : (v == MASK);
        if (m_locked[k]) begin
          if (d != m_lock_dir[k]) begin
            m_dc[k] = 1'b1; m_locked[k] = 1'b0; m_run[k] = 1; m_run_dir[k] = d;
          end
        end else begin
          if (m_run[k] > 0 && m_run_dir[k] == d) m_run[k] = (m_run[k] + 1 > lock_n[k]) ? lock_n[k] : m_run[k] + 1;
          else begin m_run[k] = 1; m_run_dir[k] = d; end
          if (m_run[k] >= lock_n[k]) begin m_locked[k] = 1'b1; m_lock_dir[k] = d; end
        end
      end else begin
        m_hold[k] = 1'b0; m_jump[k] = 1'b1; m_locked[k] = 1'b0; m_run[k] = 0;
        m_err[k]  = (m_err[k] < 255) ? m_err[k] + 1 : 255;
      end
    end
  endtask

  // compare process: after every active edge, DUT vs model
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.dir", k),        32'(o_flags[k][5]), int'(m_dir[k]));
        check($sformatf("u%0d.locked", k),     32'(o_flags[k][4]), int'(m_locked[k]));
        check($sformatf("u%0d.hold", k),       32'(o_flags[k][3]), int'(m_hold[k]));
        check($sformatf("u%0d.wrap", k),       32'(o_flags[k][2]), int'(m_wrap[k]));
        check($sformatf("u%0d.jump", k),       32'(o_flags[k][1]), int'(m_jump[k]));
        check($sformatf("u%0d.dir_change", k), 32'(o_flags[k][0]), int'(m_dc[k]));
        check($sformatf("u%0d.err_cnt", k),    32'(o_err[k]), m_err[k]);
        check($sformatf("u%0d.state", k),      32'(o_state[k]), exp_state(k));
      end
    end
  end

  // driver task: one clock of stimulus, returns after outputs were compared
  task automatic step(input bit c, input bit en, input int v);
    @(negedge clk);
    clr       = c;
    sample_en = en;
    count_in  = W'(v);
    model_apply(c, en, v);
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input int v);
    step(1'b0, 1'b1, v);
  endtask

  // literal pins: queue expected {dir,locked,hold,wrap,jump,dir_change} for u0, then compare
  task automatic pin_flags(input string name, input logic [5:0] exp);
    exp_q.push_back(W'(exp));
    check(name, 32'(o_flags[0]), int'(exp_q.pop_front()));
  endtask

  initial begin
    int v;
    bit pref;
    int r;

    model_apply(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk_on = 1'b1;
    step(1'b1, 1'b1, 77);
    pin_flags("reset_flags", 6'b000000);
    check("reset_err", 32'(o_err[0]), 0);
    check("reset_state", 32'(o_state[0]), int'(ST_INIT));

    // 5,6,7,8 locks up; LOCK_N=1 instance locks on the first step
    step(1'b0, 1'b1, 5);
    check("first_sample_state", 32'(o_state[0]), int'(ST_UNLOCKED));
    feed(6);
    check("lockn1_locked", 32'(o_flags[1][4]), 1);
    check("lockn3_not_yet", 32'(o_flags[0][4]), 0);
    feed(7);
    feed(8);
    pin_flags("lock_up_8", 6'b110000);

    // reversal while locked, then relock down
    feed(8);
    pin_flags("hold_while_locked", 6'b111000);
    feed(7);
    pin_flags("dir_change_7", 6'b000001);
    feed(6);
    feed(5);
    pin_flags("lock_down_5", 6'b010000);

    // wrap across max/0
    step(1'b1, 1'b0, 0);
    feed(254); feed(255); feed(0);
    pin_flags("wrap_on_0", 6'b100100);
    feed(1);
    pin_flags("lock_after_wrap", 6'b110000);

    // load while locked, then saturate the error counter
    step(1'b1, 1'b0, 0);
    feed(7); feed(8); feed(9); feed(10);
    feed(16);
    pin_flags("jump_on_load", 6'b100010);
    check("err_after_load", 32'(o_err[0]), 1);
    for (int i = 0; i < 300; i++) begin
      v = (m_prev + 2 + $urandom_range(0, 250)) % (MASK + 1);
      feed(v);
    end
    check("err_saturated", 32'(o_err[0]), 255);

    // hold keeps state; sample_en low freezes everything
    step(1'b1, 1'b0, 0);
    feed(17); feed(18); feed(19); feed(20); feed(20); feed(20);
    pin_flags("hold_20", 6'b111000);
    check("hold_state", 32'(o_state[0]), int'(ST_LOCK_UP));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, $urandom_range(0, MASK));
    pin_flags("frozen", 6'b111000);

    // clr beats sample_en mid-lock
    step(1'b1, 1'b1, 21);
    pin_flags("clr_mid_lock", 6'b000000);
    check("clr_state", 32'(o_state[0]), int'(ST_INIT));
    feed(90);
    pin_flags("first_after_clr", 6'b000000);

    // randomized traffic with a drifting direction preference
    pref = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) pref = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: v = pref ? m_prev + 1 : m_prev - 1;
        5, 6:          v = pref ? m_prev - 1 : m_prev + 1;
        7:             v = m_prev;
        default:       v = $urandom_range(0, MASK);
      endcase
      v = (v + MASK + 1) % (MASK + 1);
      step(r < 2, r >= 12, v);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
